// File: rtl/picorv32_axi_arb_pkg.sv
// picorv32_axi_arb_pkg
//   Shared definitions for the two-master AXI4-Lite arbiter:
//   FSM state encoding and the master-index type.
//   Build option: AXI_ARB_FIXED_PRIO_EN (consumed by picorv32_axi_arb_pick).
package picorv32_axi_arb_pkg;

  localparam int STATE_W = 3;
  localparam int MIDX_W  = 1;

  typedef logic [STATE_W-1:0] arb_state_t;
  typedef logic [MIDX_W-1:0]  midx_t;

  localparam arb_state_t ST_IDLE    = 3'd0;
  localparam arb_state_t ST_WR      = 3'd1;  // aw and w phases, in any order
  localparam arb_state_t ST_WR_RESP = 3'd2;
  localparam arb_state_t ST_RD_ADDR = 3'd3;
  localparam arb_state_t ST_RD_DATA = 3'd4;

endpackage

// File: rtl/picorv32_axi_arb_pick.sv
// picorv32_axi_arb_pick
//   Two-input grant picker.
//   Ports:
//     req[1:0]    in   pending request per master
//     last_grant  in   master that completed the previous transaction
//     grant       out  winning master (meaningful only when any=1)
//     any         out  at least one request pending
//   Build option AXI_ARB_FIXED_PRIO_EN: master 0 always wins a tie and
//   last_grant is ignored. Otherwise a tie goes to !last_grant.
module picorv32_axi_arb_pick
  import picorv32_axi_arb_pkg::*;
(
  input  logic [1:0] req,
  input  midx_t      last_grant,
  output midx_t      grant,
  output logic       any
);

  assign any = |req;

`ifdef AXI_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant = req[0] ? 1'b0 : 1'b1;
`else
  always_comb begin
    if (req == 2'b11) grant = ~last_grant;
    else              grant = req[1] ? 1'b1 : 1'b0;
  end
`endif

endmodule

// File: rtl/picorv32_axi_arbiter.sv
// picorv32_axi_arbiter
//   Shares one AXI4-Lite slave between two AXI4-Lite masters, one
//   transaction in flight at a time, round-robin on ties.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     m0_axi_* / m1_axi_*        master-side AXI4-Lite slave ports
//     s_axi_*                    slave-side AXI4-Lite master port
//     grant                      master owning the current transaction
//   Build option: AXI_ARB_FIXED_PRIO_EN (fixed priority, master 0 first).
//   Grant is registered in IDLE, so forwarding begins the cycle after a
//   request is seen. Read data is broadcast; only rvalid is steered.
module picorv32_axi_arbiter
  import picorv32_axi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  // master 0
  input  logic                    m0_axi_awvalid,
  input  logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
  input  logic [2:0]              m0_axi_awprot,
  output logic                    m0_axi_awready,
  input  logic                    m0_axi_wvalid,
  input  logic [DATA_WIDTH-1:0]   m0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
  output logic                    m0_axi_wready,
  output logic                    m0_axi_bvalid,
  input  logic                    m0_axi_bready,
  input  logic                    m0_axi_arvalid,
  input  logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
  input  logic [2:0]              m0_axi_arprot,
  output logic                    m0_axi_arready,
  output logic                    m0_axi_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_axi_rdata,
  input  logic                    m0_axi_rready,
  // master 1
  input  logic                    m1_axi_awvalid,
  input  logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  input  logic [2:0]              m1_axi_awprot,
  output logic                    m1_axi_awready,
  input  logic                    m1_axi_wvalid,
  input  logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wready,
  output logic                    m1_axi_bvalid,
  input  logic                    m1_axi_bready,
  input  logic                    m1_axi_arvalid,
  input  logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  input  logic [2:0]              m1_axi_arprot,
  output logic                    m1_axi_arready,
  output logic                    m1_axi_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic                    m1_axi_rready,
  // slave
  output logic                    s_axi_awvalid,
  output logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  output logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awready,
  output logic                    s_axi_wvalid,
  output logic [DATA_WIDTH-1:0]   s_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wready,
  input  logic                    s_axi_bvalid,
  output logic                    s_axi_bready,
  output logic                    s_axi_arvalid,
  output logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  output logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arready,
  input  logic                    s_axi_rvalid,
  input  logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                    s_axi_rready,
  output logic                    grant
);

  localparam int STRB_W = DATA_WIDTH/8;

  // master ports packed by index so the muxes can select on grant_q
  logic [1:0]                 m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
  logic [1:0][ADDR_WIDTH-1:0] m_awaddr, m_araddr;
  logic [1:0][2:0]            m_awprot, m_arprot;
  logic [1:0][DATA_WIDTH-1:0] m_wdata;
  logic [1:0][STRB_W-1:0]     m_wstrb;
  logic [1:0]                 m_awready, m_wready, m_bvalid, m_arready, m_rvalid;

  assign m_awvalid = {m1_axi_awvalid, m0_axi_awvalid};
  assign m_awaddr  = {m1_axi_awaddr,  m0_axi_awaddr};
  assign m_awprot  = {m1_axi_awprot,  m0_axi_awprot};
  assign m_wvalid  = {m1_axi_wvalid,  m0_axi_wvalid};
  assign m_wdata   = {m1_axi_wdata,   m0_axi_wdata};
  assign m_wstrb   = {m1_axi_wstrb,   m0_axi_wstrb};
  assign m_bready  = {m1_axi_bready,  m0_axi_bready};
  assign m_arvalid = {m1_axi_arvalid, m0_axi_arvalid};
  assign m_araddr  = {m1_axi_araddr,  m0_axi_araddr};
  assign m_arprot  = {m1_axi_arprot,  m0_axi_arprot};
  assign m_rready  = {m1_axi_rready,  m0_axi_rready};

  assign m0_axi_awready = m_awready[0];
  assign m1_axi_awready = m_awready[1];
  assign m0_axi_wready  = m_wready[0];
  assign m1_axi_wready  = m_wready[1];
  assign m0_axi_bvalid  = m_bvalid[0];
  assign m1_axi_bvalid  = m_bvalid[1];
  assign m0_axi_arready = m_arready[0];
  assign m1_axi_arready = m_arready[1];
  assign m0_axi_rvalid  = m_rvalid[0];
  assign m1_axi_rvalid  = m_rvalid[1];
  assign m0_axi_rdata   = s_axi_rdata;
  assign m1_axi_rdata   = s_axi_rdata;

  arb_state_t state_q, state_d;
  midx_t      grant_q, last_grant_q, pick_g;
  logic       pick_any, pick_wr;
  logic       aw_done_q, w_done_q;
  logic [1:0] req;
  logic       aw_fire, w_fire, b_fire, ar_fire, r_fire, txn_end;

  assign req = m_awvalid | m_wvalid | m_arvalid;

  picorv32_axi_arb_pick u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (pick_g),
    .any        (pick_any)
  );

  // a pending write from the winner takes precedence over its read
  assign pick_wr = m_awvalid[pick_g] | m_wvalid[pick_g];

  assign aw_fire = s_axi_awvalid & s_axi_awready;
  assign w_fire  = s_axi_wvalid  & s_axi_wready;
  assign b_fire  = s_axi_bvalid  & s_axi_bready;
  assign ar_fire = s_axi_arvalid & s_axi_arready;
  assign r_fire  = s_axi_rvalid  & s_axi_rready;
  assign txn_end = (state_q == ST_WR_RESP && b_fire) ||
                   (state_q == ST_RD_DATA && r_fire);

  assign grant = grant_q;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // grant bookkeeping and per-channel done flags
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && pick_any) grant_q <= pick_g;
      if (txn_end) last_grant_q <= grant_q;
      if (state_q == ST_WR) begin
        aw_done_q <= aw_done_q | aw_fire;
        w_done_q  <= w_done_q  | w_fire;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pick_any) state_d = pick_wr ? ST_WR : ST_RD_ADDR;
      ST_WR:      if ((aw_done_q | aw_fire) & (w_done_q | w_fire)) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_fire)  state_d = ST_IDLE;
      ST_RD_ADDR: if (ar_fire) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_fire)  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // outputs: only the granted master's channels are connected
  always_comb begin
    s_axi_awvalid = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_awprot  = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_bready  = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arprot  = '0;
    s_axi_rready  = 1'b0;
    m_awready     = '0;
    m_wready      = '0;
    m_bvalid      = '0;
    m_arready     = '0;
    m_rvalid      = '0;
    case (state_q)
      ST_WR: begin
        // a channel that already handshook is closed off on both sides
        s_axi_awvalid       = m_awvalid[grant_q] & ~aw_done_q;
        s_axi_awaddr        = m_awaddr[grant_q];
        s_axi_awprot        = m_awprot[grant_q];
        m_awready[grant_q]  = s_axi_awready & ~aw_done_q;
        s_axi_wvalid        = m_wvalid[grant_q] & ~w_done_q;
        s_axi_wdata         = m_wdata[grant_q];
        s_axi_wstrb         = m_wstrb[grant_q];
        m_wready[grant_q]   = s_axi_wready & ~w_done_q;
      end
      ST_WR_RESP: begin
        m_bvalid[grant_q]   = s_axi_bvalid;
        s_axi_bready        = m_bready[grant_q];
      end
      ST_RD_ADDR: begin
        s_axi_arvalid       = m_arvalid[grant_q];
        s_axi_araddr        = m_araddr[grant_q];
        s_axi_arprot        = m_arprot[grant_q];
        m_arready[grant_q]  = s_axi_arready;
      end
      ST_RD_DATA: begin
        m_rvalid[grant_q]   = s_axi_rvalid;
        s_axi_rready        = m_rready[grant_q];
      end
      default: ;
    endcase
  end

endmodule
